// File: rtl/rv32i_memoryaccess_lsu.sv
// RV32I stage 4 (memory access): registers the ALU result, runs data-bus loads/stores, feeds stage 5 and forwarding.
// Define MEMORYACCESS_MISALIGNED_TRAP_EN to flag misaligned halfword/word accesses instead of truncating the address.
module rv32i_memoryaccess_lsu (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ce,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [4:0]  i_rd_addr,
  input  logic        i_wr_rd,
  input  logic [31:0] i_rd,
  input  logic [31:0] i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic        i_is_load,
  input  logic        i_is_store,
  output logic        o_stall,
  output logic        o_memoryaccess_ce,
  output logic [4:0]  o_alu_rd_addr,
  output logic        o_alu_wr_rd,
  output logic        o_alu_rd_valid,
  output logic [31:0] o_alu_rd,
  output logic        o_writeback_ce,
  output logic [4:0]  o_memoryaccess_rd_addr,
  output logic        o_memoryaccess_wr_rd,
  output logic [31:0] o_writeback_rd,
  output logic        o_dbus_cyc,
  output logic        o_dbus_stb,
  output logic        o_dbus_we,
  output logic [31:0] o_dbus_addr,
  output logic [31:0] o_dbus_data,
  output logic [3:0]  o_dbus_sel,
  input  logic        i_dbus_ack,
  input  logic        i_dbus_stall,
  input  logic [31:0] i_dbus_data,
  output logic        o_misaligned
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t      state_r, next_state_s;
  logic        capture_s, issue_s, ack_s, advance_s, misaligned_s;
  logic [3:0]  sel_s;
  logic [31:0] wdata_s;
  logic        mem_ce_r, alu_wr_rd_r, alu_rd_valid_r, is_load_r, misaligned_r;
  logic [4:0]  alu_rd_addr_r;
  logic [31:0] alu_rd_r;
  logic [2:0]  funct3_r;
  logic        cyc_r, stb_r, we_r;
  logic [31:0] dbus_addr_r, dbus_data_r, load_data_r;
  logic [3:0]  dbus_sel_r;
  logic        wb_ce_r, wb_wr_rd_r;
  logic [4:0]  wb_rd_addr_r;
  logic [31:0] wb_rd_r;

  function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [2:0] f3, input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'd0, b};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = d;
    endcase
  endfunction

`ifdef MEMORYACCESS_MISALIGNED_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  assign misaligned_s = (i_is_load || i_is_store) && is_misaligned(i_funct3, i_rd[1:0]);
`else
  assign misaligned_s = 1'b0;
`endif

  assign o_stall   = (state_r != IDLE) || i_stall;
  assign capture_s = i_ce && !o_stall;
  assign issue_s   = capture_s && (i_is_load || i_is_store) && !misaligned_s;
  assign ack_s     = ((state_r == REQ) && !i_dbus_stall && i_dbus_ack) || ((state_r == WAIT) && i_dbus_ack);
  // Stage 4 is complete whenever no bus cycle is outstanding.
  assign advance_s = (state_r == IDLE) && !i_stall;

  // Byte-lane enables and lane-replicated write data for the incoming access
  always_comb begin
    sel_s   = 4'b1111;
    wdata_s = i_rs2;
    case (i_funct3[1:0])
      2'b00:   begin sel_s = 4'b0001 << i_rd[1:0];        wdata_s = {4{i_rs2[7:0]}};  end
      2'b01:   begin sel_s = 4'b0011 << {i_rd[1], 1'b0};  wdata_s = {2{i_rs2[15:0]}}; end
      default: begin sel_s = 4'b1111;                     wdata_s = i_rs2;            end
    endcase
  end

  // Bus FSM next-state
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (issue_s) next_state_s = REQ; else next_state_s = IDLE;
      REQ: begin
        if (i_dbus_stall)    next_state_s = REQ;
        else if (i_dbus_ack) next_state_s = IDLE;
        else                 next_state_s = WAIT;
      end
      WAIT:    if (i_dbus_ack) next_state_s = IDLE; else next_state_s = WAIT;
      default: next_state_s = IDLE;
    endcase
  end

  // Bus FSM state with registered cyc/stb
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
      cyc_r   <= 1'b0;
      stb_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cyc_r   <= (next_state_s != IDLE);
      stb_r   <= (next_state_s == REQ);
    end
  end

  // Stage-4 instruction registers and bus request fields, frozen until the next capture
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mem_ce_r       <= 1'b0;
      alu_rd_addr_r  <= 5'd0;
      alu_wr_rd_r    <= 1'b0;
      alu_rd_valid_r <= 1'b0;
      alu_rd_r       <= 32'd0;
      is_load_r      <= 1'b0;
      funct3_r       <= 3'd0;
      misaligned_r   <= 1'b0;
      we_r           <= 1'b0;
      dbus_addr_r    <= 32'd0;
      dbus_sel_r     <= 4'd0;
      dbus_data_r    <= 32'd0;
    end else if (capture_s) begin
      mem_ce_r       <= 1'b1;
      alu_rd_addr_r  <= i_rd_addr;
      alu_wr_rd_r    <= i_wr_rd && !misaligned_s;
      alu_rd_valid_r <= !i_is_load;
      alu_rd_r       <= i_rd;
      is_load_r      <= i_is_load;
      funct3_r       <= i_funct3;
      misaligned_r   <= misaligned_s;
      we_r           <= i_is_store;
      dbus_addr_r    <= {i_rd[31:2], 2'b00};
      dbus_sel_r     <= sel_s;
      dbus_data_r    <= wdata_s;
    end else if (advance_s || i_flush) begin
      mem_ce_r     <= 1'b0;
      misaligned_r <= 1'b0;
    end
  end

  // Load result is latched on ack so a downstream stall cannot lose it
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      load_data_r <= 32'd0;
    end else if (ack_s) begin
      load_data_r <= load_extract(i_dbus_data, funct3_r, alu_rd_r[1:0]);
    end
  end

  // Stage-5 registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wb_ce_r      <= 1'b0;
      wb_rd_addr_r <= 5'd0;
      wb_wr_rd_r   <= 1'b0;
      wb_rd_r      <= 32'd0;
    end else if (advance_s) begin
      wb_ce_r      <= mem_ce_r && !i_flush;
      wb_rd_addr_r <= alu_rd_addr_r;
      wb_wr_rd_r   <= alu_wr_rd_r;
      wb_rd_r      <= is_load_r ? load_data_r : alu_rd_r;
    end
  end

  assign o_memoryaccess_ce      = mem_ce_r;
  assign o_alu_rd_addr          = alu_rd_addr_r;
  assign o_alu_wr_rd            = alu_wr_rd_r;
  assign o_alu_rd_valid         = alu_rd_valid_r;
  assign o_alu_rd               = alu_rd_r;
  assign o_writeback_ce         = wb_ce_r;
  assign o_memoryaccess_rd_addr = wb_rd_addr_r;
  assign o_memoryaccess_wr_rd   = wb_wr_rd_r;
  assign o_writeback_rd         = wb_rd_r;
  assign o_dbus_cyc             = cyc_r;
  assign o_dbus_stb             = stb_r;
  assign o_dbus_we              = we_r;
  assign o_dbus_addr            = dbus_addr_r;
  assign o_dbus_data            = dbus_data_r;
  assign o_dbus_sel             = dbus_sel_r;
  assign o_misaligned           = misaligned_r;

endmodule

// File: doc/rv32i_memoryaccess_lsu.md
# rv32i_memoryaccess_lsu

Pipeline stage 4 (memory access) of the RV32I core: it registers the ALU-stage result and runs load/store transactions on the data bus. It also presents the stage-4 and stage-5 destination-register values that the operand-forwarding logic in the ALU stage consumes. Non-memory instructions pass through in one cycle. Loads and stores hold the pipeline until the bus acknowledges.

## Interface
Parameters:
- none

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_ce  in  1  stage 3 presents a valid instruction
- i_stall  in  1  downstream (writeback) stall
- i_flush  in  1  kill the instruction held in stage 4
- i_rd_addr  in  5  destination register
- i_wr_rd  in  1  rd will be written
- i_rd  in  32  ALU result; effective address for load/store
- i_rs2  in  32  store data
- i_funct3  in  3  load/store width/sign
- i_is_load, i_is_store  in  1 each  instruction class
- o_stall  out  1  stall stages 1-3
- o_memoryaccess_ce  out  1  stage 4 holds a valid instruction
- o_alu_rd_addr  out  5  stage-4 rd address, to forwarding
- o_alu_wr_rd  out  1  stage-4 write-enable, to forwarding
- o_alu_rd_valid  out  1  stage-4 rd value final (0 for a load)
- o_alu_rd  out  32  stage-4 rd value
- o_writeback_ce  out  1  stage 5 holds a valid instruction
- o_memoryaccess_rd_addr  out  5  stage-5 rd address
- o_memoryaccess_wr_rd  out  1  stage-5 write-enable
- o_writeback_rd  out  32  stage-5 rd value (loads extended)
- o_dbus_cyc, o_dbus_stb, o_dbus_we  out  1 each  data bus control
- o_dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_dbus_data  out  32  write data
- o_dbus_sel  out  4  byte enables
- i_dbus_ack, i_dbus_stall  in  1 each  bus response
- i_dbus_data  in  32  read data
- o_misaligned  out  1  misaligned access flag (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT.
  - IDLE->REQ: when a load/store is captured.
  - REQ->WAIT: when !i_dbus_stall.
  - REQ->IDLE: when !i_dbus_stall && i_dbus_ack in the same cycle.
  - WAIT->IDLE: on i_dbus_ack.
- o_dbus_cyc=1 in REQ/WAIT. o_dbus_stb=1 only in REQ.
- Capture: stage-4 registers load when i_ce && !o_stall.
  - o_memoryaccess_ce is set to i_ce.
  - o_memoryaccess_ce is cleared by i_flush unless i_ce captures that cycle.
- o_stall = (state!=IDLE) || i_stall.
- o_alu_rd_valid = !is_load for the held instruction. Loads force the ALU stage to stall via forwarding.
- Store encoding, where a = addr[1:0]:
  - SB: sel=4'b0001<<a; data = byte replicated x4.
  - SH: sel=4'b0011<<{a[1],1'b0}; data = halfword replicated x2.
  - SW: sel=4'b1111; data = i_rs2.
- Load extraction from i_dbus_data by a and funct3:
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: full word.
- Stage 5 advances when stage 4 is complete and !i_stall:
  - o_writeback_ce is set to o_memoryaccess_ce.
  - rd_addr and wr_rd are copied.
  - o_writeback_rd takes the load result or o_alu_rd.
- Flush during REQ/WAIT:
  - The bus cycle completes (cyc held until ack).
  - The result is discarded.
  - o_writeback_ce=0 for that instruction.

## Timing
- Reset: state=IDLE. Every output is 0: all ce, wr_rd, rd, addr, sel, cyc, stb, we, misaligned, and o_stall (o_stall still follows i_stall).
- Non-memory instruction: 1 cycle in stage 4. Reaches stage 5 on the next edge if !i_stall.
- Load/store latency = 1 (REQ) + bus stall cycles + ack wait. With zero-wait ack, data reaches stage 5 two edges after capture.
- Address, data, sel and we are stable from REQ entry until ack.
- i_dbus_ack outside REQ/WAIT is ignored.
- i_stall while stage 4 is complete: stage 4 and stage 5 hold their values, and no new bus request is issued.
- Asynchronous reset mid-transaction: cyc/stb drop immediately and the pending result is lost.

## Configuration
- MEMORYACCESS_MISALIGNED_TRAP_EN defined:
  - Halfword accesses with a[0]=1, and word accesses with a!=0, raise o_misaligned for as long as the instruction is held.
  - No bus cycle is issued (FSM stays IDLE).
  - wr_rd is forced to 0.
- Not defined:
  - o_misaligned is tied to 0.
  - Low address bits are truncated to natural alignment: a[0] is ignored for halfwords, a is ignored for words.

## Test plan
- ADD result 0x1234 to x5, no stall -> o_alu_rd=0x1234 with rd_valid=1 the cycle after capture; o_writeback_rd=0x1234 and o_writeback_ce=1 one cycle later.
- LB at 0x103, i_dbus_data=0x80FF_FF00, ack after 2 cycles -> o_stall high until ack; o_writeback_rd=0xFFFF_FF80; o_alu_rd_valid=0 while pending.
- SH at 0x202 with rs2=0xABCD -> o_dbus_sel=4'b1100, o_dbus_data=0xABCD_ABCD, o_dbus_addr=0x200, o_dbus_we=1, no rd write.
- i_dbus_stall held 3 cycles in REQ, then ack in the same cycle stall drops -> stb high 4 cycles, FSM returns directly to IDLE.
- i_flush in WAIT, then ack -> cyc stays high until ack; o_writeback_ce stays 0.
- LW at 0x102: with the macro, o_misaligned=1 and no cyc; without it, address 0x100 is accessed.
